tft_timing_gen: RTL and testbench
=================================

# tft_timing_gen

Raster timing generator and pixel output stage for the 800x480 TFT panel. Scans the frame buffer by driving row/column pointers into frame storage, samples the combinational RGB it returns, and presents registered RGB, DE and active-low HSYNC/VSYNC to the panel pins. Defaults give 928x525 cycles per frame, about 102.6 fps at 50 MHz.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (cycles)
- H_SYNC, 48, HSYNC pulse width (cycles)
- H_BP, 40, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 13, vertical front porch (lines)
- V_SYNC, 3, VSYNC pulse width (lines)
- V_BP, 29, vertical back porch (lines)

Ports:
- i_clk  in  1  pixel clock; all logic is on the rising edge
- i_rst  in  1  reset, asynchronous and active-high
- i_en  in  1  scan enable
- o_row_pixel  out  16  row pointer to frame storage
- o_col_pixel  out  16  column pointer to frame storage
- i_Red, i_Green, i_Blue  in  8 each  combinational pixel data from frame storage
- o_tft_r, o_tft_g, o_tft_b  out  8 each  registered panel RGB
- o_de  out  1  data enable, high for visible pixels
- o_hsync_n, o_vsync_n  out  1 each  active-low syncs
- o_frame_start  out  1  one-cycle pulse at the start of each frame
- o_frame_cnt  out  16  completed-frame counter, wraps

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way from the vertical parameters.
- h_cnt counts 0..H_TOTAL-1. v_cnt increments when h_cnt wraps and counts 0..V_TOTAL-1.
- Per-line segment order: active, then FP, then SYNC, then BP. The frame uses the same order in lines.
- State machine ST_IDLE / ST_RUN:
  - ST_IDLE: counters are held at 0, all outputs are at their reset values, and o_frame_cnt is held.
  - ST_IDLE to ST_RUN: on the first edge where i_en=1. The first ST_RUN cycle has h_cnt=v_cnt=0.
  - In ST_RUN, i_en is sampled only on the last cycle of a frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1).
    - i_en=0 at that cycle: next state is ST_IDLE.
    - i_en=1 at that cycle: the next frame starts.
  - i_en dropping mid-frame has no effect until the frame completes. Partial frames are never emitted.
- Pointers are registered and driven from the counters:
  - o_col_pixel = h_cnt when h_cnt<H_ACTIVE, else 0.
  - o_row_pixel = v_cnt when v_cnt<V_ACTIVE, else 0.
  - Upper pointer bits beyond the counter width are 0.
- Active pixel condition: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- HSYNC window: h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
- VSYNC window: v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. It covers whole lines, starting at h_cnt=0.
- Output register, one stage:
  - o_de is the active condition, delayed one cycle.
  - o_hsync_n and o_vsync_n are the inverted window conditions, delayed one cycle.
  - o_tft_* samples i_* when the condition is active, else 0.
- o_frame_start is high for exactly one cycle: the cycle after h_cnt=v_cnt=0 in ST_RUN, aligned with o_de of pixel (0,0).
- o_frame_cnt increments by 1 on the last cycle of each completed frame. It wraps from 65535 to 0.

## Timing
- Reset values: o_row_pixel=0, o_col_pixel=0, o_tft_*=0, o_de=0, o_hsync_n=1, o_vsync_n=1, o_frame_start=0, o_frame_cnt=0, state ST_IDLE.
- Asserting i_rst at any point, including mid-line or mid-sync, forces reset values immediately, without waiting for a clock edge.
- After i_rst deasserts with i_en=1:
  - Edge 1: state is ST_RUN and pointers are (0,0).
  - Edge 2: o_de=1, o_frame_start=1, and o_tft_* equals the storage data for (0,0).
- Pointer-to-pin latency is exactly 1 cycle. Frame storage must be combinational in the same cycle.
- Line period is H_TOTAL cycles. Frame period is H_TOTAL*V_TOTAL cycles (487200 at defaults).
- o_de is high for 800 consecutive cycles per visible line and 480 lines per frame.

## Test plan
- Reset: assert i_rst mid-line while o_hsync_n=0 -> all outputs return to reset values immediately. Deassert with i_en=1 -> first o_de two edges later.
- Data alignment: stub storage returns R=col[7:0], G=row[7:0], B=0x5A.
  - Each o_de cycle -> o_tft_r=(prior o_col_pixel)[7:0] and o_tft_g=(prior o_row_pixel)[7:0].
  - o_tft_*=0 whenever o_de=0.
- Line timing: count cycles from the first o_de of a line -> o_de 800 cycles, 40 low, then o_hsync_n low 48 cycles, 40 more low, next line's o_de at cycle 928.
- Frame timing:
  - o_vsync_n low for exactly 3*928=2784 cycles, starting 493 lines after frame start.
  - o_frame_start pulses exactly 487200 cycles apart.
  - o_frame_cnt increments once per frame.
- Enable: drop i_en at line 100 of frame 0 -> frame 0 completes, o_frame_cnt=1, block idles with o_hsync_n=o_vsync_n=1. Raise i_en -> new frame starts on the next edge.
- Wrap: preload or run o_frame_cnt to 65535 -> the next frame completion gives 0.

Source files
------------

// File: rtl/tft_timing_gen.sv
// Raster timing generator and registered pixel output stage for an 800x480 TFT panel.
// Drives row/column pointers into combinational frame storage and registers RGB, DE and syncs.
module tft_timing_gen #(
    parameter int          H_ACTIVE       = 800,
    parameter int          H_FP           = 40,
    parameter int          H_SYNC         = 48,
    parameter int          H_BP           = 40,
    parameter int          V_ACTIVE       = 480,
    parameter int          V_FP           = 13,
    parameter int          V_SYNC         = 3,
    parameter int          V_BP           = 29,
    parameter logic [15:0] FRAME_CNT_INIT = 16'd0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    output logic [15:0] o_row_pixel,
    output logic [15:0] o_col_pixel,
    input  logic [7:0]  i_Red,
    input  logic [7:0]  i_Green,
    input  logic [7:0]  i_Blue,
    output logic [7:0]  o_tft_r,
    output logic [7:0]  o_tft_g,
    output logic [7:0]  o_tft_b,
    output logic        o_de,
    output logic        o_hsync_n,
    output logic        o_vsync_n,
    output logic        o_frame_start,
    output logic [15:0] o_frame_cnt,
    output logic        o_dbg_state
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_BEG_C = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END_C = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_BEG_C = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END_C = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [15:0]   col_q, col_d;
    logic [15:0]   row_q, row_d;
    logic [7:0]    r_q, r_d;
    logic [7:0]    g_q, g_d;
    logic [7:0]    b_q, b_d;
    logic          de_q, de_d;
    logic          hs_n_q, hs_n_d;
    logic          vs_n_q, vs_n_d;
    logic          fs_q, fs_d;
    logic [15:0]   fcnt_q, fcnt_d;

    logic run;
    logic h_last;
    logic v_last;
    logic active;
    logic hs_win;
    logic vs_win;

    always_comb begin
        run    = (state_q == ST_RUN);
        h_last = (h_cnt_q == H_LAST_C);
        v_last = (v_cnt_q == V_LAST_C);

        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        fcnt_d  = fcnt_q;

        // Enable is only honoured at the final cycle of a frame, so frames are never cut short.
        case (state_q)
            ST_IDLE: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (i_en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (h_last) begin
                    h_cnt_d = '0;
                    if (v_last) begin
                        v_cnt_d = '0;
                        fcnt_d  = fcnt_q + 16'd1;
                        if (!i_en) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        v_cnt_d = v_cnt_q + VW'(1);
                    end
                end else begin
                    h_cnt_d = h_cnt_q + HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                h_cnt_d = '0;
                v_cnt_d = '0;
            end
        endcase

        active = run && (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
        hs_win = run && (h_cnt_q >= HS_BEG_C) && (h_cnt_q <= HS_END_C);
        vs_win = run && (v_cnt_q >= VS_BEG_C) && (v_cnt_q <= VS_END_C);

        // Pointers track the next counter value so storage data lines up with the current count.
        col_d = (h_cnt_d < H_ACT_C) ? 16'(h_cnt_d) : 16'd0;
        row_d = (v_cnt_d < V_ACT_C) ? 16'(v_cnt_d) : 16'd0;

        r_d    = active ? i_Red   : 8'd0;
        g_d    = active ? i_Green : 8'd0;
        b_d    = active ? i_Blue  : 8'd0;
        de_d   = active;
        hs_n_d = ~hs_win;
        vs_n_d = ~vs_win;
        fs_d   = run && (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            col_q   <= 16'd0;
            row_q   <= 16'd0;
            r_q     <= 8'd0;
            g_q     <= 8'd0;
            b_q     <= 8'd0;
            de_q    <= 1'b0;
            hs_n_q  <= 1'b1;
            vs_n_q  <= 1'b1;
            fs_q    <= 1'b0;
            fcnt_q  <= FRAME_CNT_INIT;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            de_q    <= de_d;
            hs_n_q  <= hs_n_d;
            vs_n_q  <= vs_n_d;
            fs_q    <= fs_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign o_row_pixel   = row_q;
    assign o_col_pixel   = col_q;
    assign o_tft_r       = r_q;
    assign o_tft_g       = g_q;
    assign o_tft_b       = b_q;
    assign o_de          = de_q;
    assign o_hsync_n     = hs_n_q;
    assign o_vsync_n     = vs_n_q;
    assign o_frame_start = fs_q;
    assign o_frame_cnt   = fcnt_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_tft_timing_gen.sv
// Bench for tft_timing_gen using a reduced raster; expected outputs come from a
// linear-position model of the frame (pixel index within frame, div/mod for line/column).
module tb_tft_timing_gen;

    localparam int HA = 16, HF = 3, HS = 4, HB = 5;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic [15:0] WRAP_INIT = 16'hFFFE;

    logic        clk, rst, en, rst2;
    logic [15:0] row, col, fcnt, row2, col2, fcnt2;
    logic [7:0]  r, g, b, r2, g2, b2;
    logic [7:0]  red, green, blue, red2, green2, blue2;
    logic        de, hs_n, vs_n, fs, st;
    logic        de2, hs_n2, vs_n2, fs2, st2;
    int          n_checks, n_fail;

    // Frame storage stubs: R = column, G = row, B = constant.
    assign red    = col[7:0];
    assign green  = row[7:0];
    assign blue   = 8'h5A;
    assign red2   = col2[7:0];
    assign green2 = row2[7:0];
    assign blue2  = 8'h5A;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    tft_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .o_row_pixel(row), .o_col_pixel(col),
        .i_Red(red), .i_Green(green), .i_Blue(blue),
        .o_tft_r(r), .o_tft_g(g), .o_tft_b(b),
        .o_de(de), .o_hsync_n(hs_n), .o_vsync_n(vs_n),
        .o_frame_start(fs), .o_frame_cnt(fcnt), .o_dbg_state(st)
    );

    tft_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FRAME_CNT_INIT(WRAP_INIT)
    ) dut_wrap (
        .i_clk(clk), .i_rst(rst2), .i_en(1'b1),
        .o_row_pixel(row2), .o_col_pixel(col2),
        .i_Red(red2), .i_Green(green2), .i_Blue(blue2),
        .o_tft_r(r2), .o_tft_g(g2), .o_tft_b(b2),
        .o_de(de2), .o_hsync_n(hs_n2), .o_vsync_n(vs_n2),
        .o_frame_start(fs2), .o_frame_cnt(fcnt2), .o_dbg_state(st2)
    );

    // ---------------- reference model ----------------
    logic        m_run;
    int          m_pos;
    logic [15:0] m_fcnt;
    logic        exp_de, exp_hs_n, exp_vs_n, exp_fs;
    logic [7:0]  exp_r, exp_g, exp_b;
    logic [15:0] exp_col, exp_row;

    function automatic logic is_act(int p);
        return ((p % HT) < HA) && ((p / HT) < VA);
    endfunction

    function automatic logic in_hsync(int p);
        return ((p % HT) >= HA + HF) && ((p % HT) < HA + HF + HS);
    endfunction

    function automatic logic in_vsync(int p);
        return ((p / HT) >= VA + VF) && ((p / HT) < VA + VF + VS);
    endfunction

    function automatic int nxt_pos(logic run_now, int p);
        if (!run_now || p == FRAME - 1) return 0;
        return p + 1;
    endfunction

    function automatic logic nxt_run(logic run_now, int p, logic e);
        if (!run_now || p == FRAME - 1) return e;
        return 1'b1;
    endfunction

    function automatic logic [15:0] ptr_col(logic run_now, int p);
        return (run_now && (p % HT) < HA) ? 16'(p % HT) : 16'd0;
    endfunction

    function automatic logic [15:0] ptr_row(logic run_now, int p);
        return (run_now && (p / HT) < VA) ? 16'(p / HT) : 16'd0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run    <= 1'b0;
            m_pos    <= 0;
            m_fcnt   <= 16'd0;
            exp_de   <= 1'b0;
            exp_hs_n <= 1'b1;
            exp_vs_n <= 1'b1;
            exp_fs   <= 1'b0;
            exp_r    <= 8'd0;
            exp_g    <= 8'd0;
            exp_b    <= 8'd0;
            exp_col  <= 16'd0;
            exp_row  <= 16'd0;
        end else begin
            exp_de   <= m_run && is_act(m_pos);
            exp_hs_n <= !(m_run && in_hsync(m_pos));
            exp_vs_n <= !(m_run && in_vsync(m_pos));
            exp_fs   <= m_run && (m_pos == 0);
            exp_r    <= (m_run && is_act(m_pos)) ? 8'(m_pos % HT) : 8'd0;
            exp_g    <= (m_run && is_act(m_pos)) ? 8'(m_pos / HT) : 8'd0;
            exp_b    <= (m_run && is_act(m_pos)) ? 8'h5A : 8'd0;
            exp_col  <= ptr_col(nxt_run(m_run, m_pos, en), nxt_pos(m_run, m_pos));
            exp_row  <= ptr_row(nxt_run(m_run, m_pos, en), nxt_pos(m_run, m_pos));
            if (m_run && m_pos == FRAME - 1) m_fcnt <= m_fcnt + 16'd1;
            m_run    <= nxt_run(m_run, m_pos, en);
            m_pos    <= nxt_pos(m_run, m_pos);
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; en = 1'b0; rst2 = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({de, hs_n, vs_n, fs} !== 4'b0110) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0110", {de, hs_n, vs_n, fs});
        end
        n_checks++;
        if ({r, g, b} !== 24'd0) begin
            n_fail++; $display("FAIL reset_rgb: got %h expected 000000", {r, g, b});
        end
        n_checks++;
        if ({row, col} !== 32'd0) begin
            n_fail++; $display("FAIL reset_ptr: got row %0d col %0d expected 0 0", row, col);
        end
        n_checks++;
        if (fcnt !== 16'd0 || st !== 1'b0) begin
            n_fail++; $display("FAIL reset_cnt_state: got fcnt %0d state %b expected 0 0", fcnt, st);
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            n_checks++;
            if ({st, de, hs_n, vs_n, fs} !== 5'b00110 || fcnt !== 16'd0) begin
                n_fail++; $display("FAIL idle_hold: got st/de/hs/vs/fs %b fcnt %0d expected 00110 0",
                                   {st, de, hs_n, vs_n, fs}, fcnt);
            end
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        seen = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 2 * FRAME && !seen; k++) begin
            @(negedge clk);
            if (hs_n === 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL async_wait_hsync: got no hsync within %0d cycles expected one", 2 * FRAME);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({st, de, hs_n, vs_n, fs} !== 5'b00110) begin
            n_fail++; $display("FAIL async_ctrl: got %b expected 00110", {st, de, hs_n, vs_n, fs});
        end
        n_checks++;
        if ({r, g, b} !== 24'd0 || {row, col} !== 32'd0 || fcnt !== 16'd0) begin
            n_fail++; $display("FAIL async_data: got rgb %h row %0d col %0d fcnt %0d expected all 0",
                               {r, g, b}, row, col, fcnt);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (st !== 1'b1 || {row, col} !== 32'd0 || de !== 1'b0) begin
            n_fail++; $display("FAIL start_edge1: got st %b row %0d col %0d de %b expected 1 0 0 0", st, row, col, de);
        end
        @(posedge clk); #1;
        n_checks++;
        if (de !== 1'b1 || fs !== 1'b1 || {r, g, b} !== 24'h00005A) begin
            n_fail++; $display("FAIL start_edge2: got de %b fs %b rgb %h expected 1 1 00005a", de, fs, {r, g, b});
        end
    endtask

    task automatic test_data_alignment();
        for (int k = 0; k < 3 * FRAME; k++) begin
            @(negedge clk);
            n_checks++;
            if ({de, hs_n, vs_n, fs} !== {exp_de, exp_hs_n, exp_vs_n, exp_fs}) begin
                n_fail++; $display("FAIL align_ctrl @%0d: got %b expected %b", k,
                                   {de, hs_n, vs_n, fs}, {exp_de, exp_hs_n, exp_vs_n, exp_fs});
            end
            n_checks++;
            if ({r, g, b} !== {exp_r, exp_g, exp_b}) begin
                n_fail++; $display("FAIL align_rgb @%0d: got %h expected %h", k, {r, g, b}, {exp_r, exp_g, exp_b});
            end
            n_checks++;
            if (row !== exp_row || col !== exp_col) begin
                n_fail++; $display("FAIL align_ptr @%0d: got row %0d col %0d expected %0d %0d", k, row, col, exp_row, exp_col);
            end
            n_checks++;
            if (fcnt !== m_fcnt || st !== m_run) begin
                n_fail++; $display("FAIL align_cnt_state @%0d: got fcnt %0d st %b expected %0d %b", k, fcnt, st, m_fcnt, m_run);
            end
            en = ($urandom_range(0, 5) != 0);
        end
        en = 1'b1;
    endtask

    task automatic test_line_timing();
        logic de_a [0:HT];
        logic hs_a [0:HT];
        bit   seen;
        int   ones, first_de_low, first_hs_low, last_hs_low, hs_lows;
        en = 1'b1; seen = 1'b0;
        for (int k = 0; k < 3 * FRAME && !seen; k++) begin
            @(negedge clk);
            if (fs === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL line_wait_fs: got no frame start expected one");
        end
        for (int i = 0; i <= HT; i++) begin
            if (i > 0) @(negedge clk);
            de_a[i] = de;
            hs_a[i] = hs_n;
        end
        ones = 0; first_de_low = -1; first_hs_low = -1; last_hs_low = -1; hs_lows = 0;
        for (int i = 0; i < HT; i++) begin
            if (de_a[i] === 1'b1) ones++;
            else if (first_de_low < 0) first_de_low = i;
            if (hs_a[i] === 1'b0) begin
                hs_lows++;
                last_hs_low = i;
                if (first_hs_low < 0) first_hs_low = i;
            end
        end
        n_checks++;
        if (ones != HA || first_de_low != HA) begin
            n_fail++; $display("FAIL line_de: got %0d high, first low at %0d expected %0d %0d", ones, first_de_low, HA, HA);
        end
        n_checks++;
        if (first_hs_low != HA + HF || last_hs_low != HA + HF + HS - 1 || hs_lows != HS) begin
            n_fail++; $display("FAIL line_hsync: got low %0d..%0d count %0d expected %0d..%0d count %0d",
                               first_hs_low, last_hs_low, hs_lows, HA + HF, HA + HF + HS - 1, HS);
        end
        n_checks++;
        if (de_a[HT] !== 1'b1) begin
            n_fail++; $display("FAIL line_period: got de %b at cycle %0d expected 1", de_a[HT], HT);
        end
    endtask

    task automatic test_frame_timing();
        bit          seen;
        int          vs_first, vs_cnt, fs_idx, fc_changes;
        logic [15:0] fc0, fc_prev;
        en = 1'b1; seen = 1'b0;
        for (int k = 0; k < 3 * FRAME && !seen; k++) begin
            @(negedge clk);
            if (fs === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL frame_wait_fs: got no frame start expected one");
        end
        fc0 = fcnt; fc_prev = fcnt;
        vs_first = -1; vs_cnt = 0; fs_idx = -1; fc_changes = 0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (vs_n === 1'b0) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = k;
            end
            if (fs === 1'b1 && fs_idx < 0) fs_idx = k;
            if (fcnt !== fc_prev) fc_changes++;
            fc_prev = fcnt;
        end
        n_checks++;
        if (fs_idx != FRAME) begin
            n_fail++; $display("FAIL frame_period: got next frame start at %0d expected %0d", fs_idx, FRAME);
        end
        n_checks++;
        if (vs_first != (VA + VF) * HT || vs_cnt != VS * HT) begin
            n_fail++; $display("FAIL frame_vsync: got start %0d width %0d expected %0d %0d",
                               vs_first, vs_cnt, (VA + VF) * HT, VS * HT);
        end
        n_checks++;
        if (fcnt !== fc0 + 16'd1 || fc_changes != 1) begin
            n_fail++; $display("FAIL frame_cnt: got %0d after %0d changes expected %0d after 1",
                               fcnt, fc_changes, fc0 + 16'd1);
        end
    endtask

    task automatic test_enable();
        bit          seen;
        int          idle_idx;
        logic [15:0] fc0;
        en = 1'b1; seen = 1'b0;
        for (int k = 0; k < 3 * FRAME && !seen; k++) begin
            @(negedge clk);
            if (fs === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL enable_wait_fs: got no frame start expected one");
        end
        fc0 = fcnt; idle_idx = -1;
        for (int k = 1; k <= 2 * FRAME && idle_idx < 0; k++) begin
            @(negedge clk);
            if (k == 3 * HT + 5) en = 1'b0;
            if (st === 1'b0) idle_idx = k;
        end
        n_checks++;
        if (idle_idx != FRAME - 1) begin
            n_fail++; $display("FAIL enable_complete: got idle at %0d expected %0d", idle_idx, FRAME - 1);
        end
        repeat (8) begin
            n_checks++;
            if ({st, de, hs_n, vs_n, fs} !== 5'b00110 || fcnt !== fc0 + 16'd1) begin
                n_fail++; $display("FAIL enable_idle: got st/de/hs/vs/fs %b fcnt %0d expected 00110 %0d",
                                   {st, de, hs_n, vs_n, fs}, fcnt, fc0 + 16'd1);
            end
            @(negedge clk);
        end
        en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (st !== 1'b1 || fs !== 1'b0) begin
            n_fail++; $display("FAIL enable_restart: got st %b fs %b expected 1 0", st, fs);
        end
        @(negedge clk);
        n_checks++;
        if (fs !== 1'b1 || de !== 1'b1) begin
            n_fail++; $display("FAIL enable_first_pixel: got fs %b de %b expected 1 1", fs, de);
        end
    endtask

    task automatic test_wrap();
        rst2 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (fcnt2 !== WRAP_INIT) begin
            n_fail++; $display("FAIL wrap_preload: got %0d expected %0d", fcnt2, WRAP_INIT);
        end
        rst2 = 1'b0;
        repeat (FRAME) @(negedge clk);
        n_checks++;
        if (fcnt2 !== 16'hFFFE) begin
            n_fail++; $display("FAIL wrap_hold: got %0d expected 65534", fcnt2);
        end
        @(negedge clk);
        n_checks++;
        if (fcnt2 !== 16'hFFFF) begin
            n_fail++; $display("FAIL wrap_max: got %0d expected 65535", fcnt2);
        end
        repeat (FRAME) @(negedge clk);
        n_checks++;
        if (fcnt2 !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_zero: got %0d expected 0", fcnt2);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        rst2     = 1'b1;
        en       = 1'b0;
        test_reset();
        test_async_reset();
        test_data_alignment();
        test_line_timing();
        test_frame_timing();
        test_enable();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
